// File: rtl/seg7_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scanner.
// Segment patterns here are high-true {g,f,e,d,c,b,a}; polarity is applied at the output registers.
package seg7_pkg;

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    function automatic int cnt_width(input int refresh_div);
        return $clog2(refresh_div);
    endfunction

    function automatic int idx_width(input int num_digits);
        return (num_digits > 1) ? $clog2(num_digits) : 1;
    endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Debug-word load port and display pins of the seven-segment scanner.
interface seg7_scan_display_if #(
    parameter int NUM_DIGITS = 8
);
    // Load is a one-cycle strobe that is always accepted (no ready); Value/Dp/Blank/Lzb are
    // sampled on the same rising edge and must be stable while Load is high.
    logic [4*NUM_DIGITS-1:0] Value;
    logic [NUM_DIGITS-1:0]   Dp;
    logic [NUM_DIGITS-1:0]   Blank;
    logic                    Lzb;
    logic                    Load;
    logic [6:0]              out7;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   en_out;
    logic                    frame_tick;

    modport master (
        output Value, Dp, Blank, Lzb, Load,
        input  out7, dp_out, en_out, frame_tick
    );

    modport slave (
        input  Value, Dp, Blank, Lzb, Load,
        output out7, dp_out, en_out, frame_tick
    );
endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to high-true seven-segment pattern.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    assign o_seg = hex_to_seg(i_nib);
endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed hex display scanner: double-buffered digits, leading-zero blanking,
// and an all-dark guard interval at the start of every digit slot to stop ghosting.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 16,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                              Clk,
    input  logic                              Reset,
    seg7_scan_display_if.slave                bus,
    output scan_state_e                       o_dbg_state,
    output logic [idx_width(NUM_DIGITS)-1:0]  o_dbg_idx
);
    localparam int CW = cnt_width(REFRESH_DIV);
    localparam int IW = idx_width(NUM_DIGITS);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD - 1);
    localparam logic [CW-1:0] DRIVE_END = CW'(REFRESH_DIV - GUARD - 1);
    localparam logic [CW-1:0] TICK_AT   = CW'(REFRESH_DIV - GUARD - 2);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_POL = {7{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] EN_POL  = {NUM_DIGITS{ACTIVE_LOW}};

    scan_state_e r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [IW-1:0] r_idx, w_idx_nx;
    logic r_run, r_tick, w_tick_nx, w_show, w_dark;

    logic [NUM_DIGITS-1:0][3:0] r_pend_val, r_act_val;
    logic [NUM_DIGITS-1:0] r_pend_dp, r_pend_blank, r_act_dp, r_act_blank;
    logic r_pend_lzb, r_act_lzb, r_pend_valid;

    logic [6:0] r_out7, w_seg_raw, w_seg;
    logic r_dp_out;
    logic [NUM_DIGITS-1:0] r_en_out, w_onehot, w_lz_dark;

    // The active buffer only changes on the edge that closes a frame, so a frame never mixes data.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_pend_lzb   <= 1'b0;
            r_pend_valid <= 1'b0;
            r_act_val    <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '0;
            r_act_lzb    <= 1'b0;
        end else begin
            if (r_tick && r_pend_valid) begin
                r_act_val   <= r_pend_val;
                r_act_dp    <= r_pend_dp;
                r_act_blank <= r_pend_blank;
                r_act_lzb   <= r_pend_lzb;
            end
            if (bus.Load) begin
                r_pend_val   <= bus.Value;
                r_pend_dp    <= bus.Dp;
                r_pend_blank <= bus.Blank;
                r_pend_lzb   <= bus.Lzb;
            end
            r_pend_valid <= bus.Load | (r_pend_valid & ~r_tick);
        end
    end

    always_comb begin : lz_scan
        logic all_zero;
        all_zero  = 1'b1;
        w_lz_dark = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero     = all_zero & (r_act_val[i] == 4'h0);
            w_lz_dark[i] = r_act_lzb & all_zero & (i != 0);
        end
    end

    seg7_hex_decoder u_dec (
        .i_nib (r_act_val[r_idx]),
        .o_seg (w_seg_raw)
    );

    always_comb begin
        w_onehot        = '0;
        w_onehot[r_idx] = 1'b1;
        w_dark          = r_act_blank[r_idx] | w_lz_dark[r_idx];
        w_seg           = w_dark ? 7'h00 : w_seg_raw;
    end

    // w_show says whether the cycle after this edge is a DRIVE cycle.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_show     = 1'b0;
        w_tick_nx  = 1'b0;
        if (r_run) begin
            w_cnt_nx = r_cnt + 1'b1;
            case (r_state)
                ST_GUARD: begin
                    if (r_cnt == GUARD_END) begin
                        w_state_nx = ST_DRIVE;
                        w_cnt_nx   = '0;
                        w_show     = 1'b1;
                    end
                end
                ST_DRIVE: begin
                    if (r_cnt == DRIVE_END) begin
                        w_state_nx = ST_GUARD;
                        w_cnt_nx   = '0;
                        w_idx_nx   = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                    end else begin
                        w_show    = 1'b1;
                        w_tick_nx = (r_idx == LAST_IDX) && (r_cnt == TICK_AT);
                    end
                end
                default: ;
            endcase
        end
    end

    // r_run holds the scan for one edge after reset release so the first guard starts on that edge.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state  <= ST_GUARD;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_run    <= 1'b0;
            r_tick   <= 1'b0;
            r_out7   <= SEG_POL;
            r_dp_out <= ACTIVE_LOW;
            r_en_out <= EN_POL;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_idx    <= w_idx_nx;
            r_run    <= 1'b1;
            r_tick   <= w_tick_nx;
            r_out7   <= (w_show ? w_seg : 7'h00) ^ SEG_POL;
            r_dp_out <= (w_show & r_act_dp[r_idx]) ^ ACTIVE_LOW;
            r_en_out <= (w_show ? w_onehot : '0) ^ EN_POL;
        end
    end

    assign bus.out7       = r_out7;
    assign bus.dp_out     = r_dp_out;
    assign bus.en_out     = r_en_out;
    assign bus.frame_tick = r_tick;
    assign o_dbg_state    = r_state;
    assign o_dbg_idx      = r_idx;

endmodule

// File: doc/seg7_scan_display.md
# seg7_scan_display

Parametrised multiplexed seven-segment driver for the board top level. Replaces the fixed two-by-four-digit display with one scanner of NUM_DIGITS hex digits. Adds per-digit decimal points, per-digit blanking, leading-zero suppression, tear-free double-buffered loading and an anti-ghosting guard interval. It runs on the undivided board clock and displays debug words (registers, PC) from the CPU.

## Interface
- NUM_DIGITS, 8: digits scanned; 1..16.
- REFRESH_DIV, 100000: Clk cycles per digit slot; ≥ GUARD+2.
- GUARD, 16: cycles at the start of each slot with all anodes off; ≥1.
- ACTIVE_LOW, 1: 1 means segments, dp and anodes are driven low-true (board default); 0 means high-true.

- Clk  in  1: board clock; all state on rising edge.
- Reset  in  1: asynchronous, active-low; assertion clears all state immediately.
- Value  in  4*NUM_DIGITS: hex nibbles; digit i = Value[4i+3:4i]; digit 0 is rightmost.
- Dp  in  NUM_DIGITS: decimal point per digit.
- Blank  in  NUM_DIGITS: force digit dark.
- Lzb  in  1: leading-zero blanking enable.
- Load  in  1: one-cycle strobe; captures Value/Dp/Blank/Lzb into the pending buffer.
- out7  out  7: segments {g,f,e,d,c,b,a}; out7[0]=a.
- dp_out  out  1: decimal point.
- en_out  out  NUM_DIGITS: one-hot anode enables.
- frame_tick  out  1: one-cycle pulse at end of each full scan.

## Operation
- Two buffers, pending and active, each holding Value, Dp, Blank and Lzb, plus a pend_valid flag.
  - Load writes pending and sets pend_valid.
  - At each frame boundary, if pend_valid, active ← pending and pend_valid clears.
  - If Load coincides with the boundary, the old pending transfers, the new data is written to pending, and pend_valid stays 1.
- The display shows only the active buffer. Before the first transfer, active is all-zero, so digit 0 shows "0" and every other digit, if Lzb=0, also shows "0".
- Scan state machine:
  - GUARD: anodes off, segments off. After GUARD cycles → DRIVE.
  - DRIVE: en_out[idx] asserted, segments for digit idx. After REFRESH_DIV−GUARD cycles → GUARD, and idx ← idx+1, wrapping NUM_DIGITS−1 → 0.
- Leading-zero blanking: when active Lzb=1, digit i is dark if all nibbles at i..NUM_DIGITS−1 are zero. Digit 0 is never blanked by Lzb.
- A digit is dark if Blank[i] or Lzb suppresses it. When dark, its anode is still asserted in DRIVE, segments are off, and dp_out follows Dp[i].
- Hex decode: standard gfedcba, high-true values (0..F):
  - 0..7: 3F 06 5B 4F 66 6D 7D 07
  - 8..F: 7F 6F 77 7C 39 5E 79 71
  - With ACTIVE_LOW=1, all of out7, dp_out and en_out are bitwise inverted.

## Timing
- All outputs are registered. out7, dp_out and en_out change on the same edge as the state transition.
- Slot length is exactly REFRESH_DIV cycles. Frame length is NUM_DIGITS·REFRESH_DIV cycles.
- frame_tick is high during the last cycle of digit NUM_DIGITS−1's DRIVE phase.
- The buffer transfer happens on the edge that ends that cycle. The first DRIVE of digit 0 in the next frame shows the new data.
- Latency from Load to visible data: at most one frame + GUARD + 1 cycles.
- Reset (asynchronous, low) puts the block in the following state:
  - state GUARD, idx 0, slot counter 0
  - both buffers zero, pend_valid 0, frame_tick 0
  - en_out, out7 and dp_out at their inactive level (all-ones when ACTIVE_LOW=1)
- Reset asserted mid-slot or mid-frame takes effect immediately; a partial Load is discarded.
- Deassertion: first GUARD begins on the first rising edge after release.

## Structure
- Package seg7_pkg holds:
  - the hex-to-segment function or constant table (high-true)
  - the state enum {GUARD, DRIVE}
  - a counter-width helper ($clog2 of REFRESH_DIV)
- Sub-module seg7_hex_decoder (4-bit in → 7-bit high-true segments) is combinational. Polarity inversion is applied in the output register stage.
- Counter width: $clog2(REFRESH_DIV). Index width: max(1, $clog2(NUM_DIGITS)).

## Test plan
Parameters for all scenarios: NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2, ACTIVE_LOW=1.

- Reset then hold: en_out=4'hF, out7=7'h7F, dp_out=1, frame_tick=0 throughout reset.
  - After release: 2 cycles anodes off, then en_out=4'hE, out7=7'h40 ("0") for 6 cycles.
- Load Value=16'h12AF, Dp=4'b0100, Lzb=0, then wait for transfer. Expected per digit:
  - digit0 en_out=E, out7=0E ("F")
  - digit1 en_out=D, out7=08 ("A")
  - digit2 en_out=B, out7=24 ("2"), dp_out=0
  - digit3 en_out=7, out7=79 ("1")
  - frame_tick every 32 cycles.
- Load Value=16'h0030, Lzb=1: digits 3 and 2 have segments off, with anodes still cycling. Digit1 = 30 ("3"), digit0 = 40 ("0").
  - Then Value=0: only digit0 lit.
- Load on the exact frame_tick cycle: the frame after shows the previous pending data, the frame after that shows the new data.
- Two Loads within one frame: only the second value appears. No digit ever shows a mix of old and new within one frame.
- Assert Reset mid-DRIVE of digit 2: outputs go inactive the same cycle, without waiting for a clock edge. After release, scanning restarts at digit 0 with active data zero.
